// File: rtl/trigger_unit_pkg.sv
// Shared widths and state encodings for the trigger unit (define.v equivalents).
// The build flag TRIGGER_EXT_EN adds the external trigger input to trigger_unit.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef COUNT_WIDTH
`define COUNT_WIDTH 8
`endif
`ifndef TRIG_IDLE
`define TRIG_IDLE 2'd0
`endif
`ifndef TRIG_ARMED
`define TRIG_ARMED 2'd1
`endif
`ifndef TRIG_TRIGGERED
`define TRIG_TRIGGERED 2'd2
`endif

package trigger_unit_pkg;

  localparam int DEFAULT_DATA_WIDTH  = `DATA_WIDTH;
  localparam int DEFAULT_COUNT_WIDTH = `COUNT_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE      = `TRIG_IDLE,
    ST_ARMED     = `TRIG_ARMED,
    ST_TRIGGERED = `TRIG_TRIGGERED
  } trig_state_t;

endpackage

// File: rtl/trigger_unit_match.sv
// Combinational level/edge comparator: current sample against the latched config.
module trigger_match #(
  parameter int DATA_WIDTH = trigger_unit_pkg::DEFAULT_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [DATA_WIDTH-1:0] prev,
  input  logic                  prev_valid,
  input  logic [DATA_WIDTH-1:0] mask,
  input  logic [DATA_WIDTH-1:0] value,
  input  logic [DATA_WIDTH-1:0] edge_mask,
  output logic                  match
);

  logic [DATA_WIDTH-1:0] edge_bit_ok;
  logic                  level_ok;
  logic                  edge_ok;

  assign level_ok = ((data ^ value) & mask) == '0;

  // A bit outside edge_mask is always satisfied, so an all-zero edge_mask
  // never depends on prev_valid.
  generate
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_edge
      assign edge_bit_ok[gi] = !edge_mask[gi] ||
                               (prev_valid && (prev[gi] != data[gi]) && (data[gi] == value[gi]));
    end
  endgenerate

  assign edge_ok = &edge_bit_ok;
  assign match   = level_ok && edge_ok;

endmodule

// File: rtl/trigger_unit.sv
// Programmable occurrence-counting trigger feeding the capture core's i_trigger.
// Build flag TRIGGER_EXT_EN adds i_ext_trigger, which forces TRIGGERED from ARMED.
module trigger_unit
  import trigger_unit_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  i_data,
  input  logic                   i_arm,
  input  logic                   i_disarm,
  input  logic [DATA_WIDTH-1:0]  i_mask,
  input  logic [DATA_WIDTH-1:0]  i_value,
  input  logic [DATA_WIDTH-1:0]  i_edge_mask,
  input  logic [COUNT_WIDTH-1:0] i_count,
`ifdef TRIGGER_EXT_EN
  input  logic                   i_ext_trigger,
`endif
  output logic                   o_trigger,
  output logic                   o_armed,
  output logic [COUNT_WIDTH-1:0] o_match_cnt
);

  trig_state_t            state_reg, state_next;
  logic [COUNT_WIDTH-1:0] cnt_reg, cnt_next;
  logic [DATA_WIDTH-1:0]  mask_reg, value_reg, edge_mask_reg;
  logic [COUNT_WIDTH-1:0] count_reg;
  logic [DATA_WIDTH-1:0]  prev_reg;
  logic                   prev_valid_reg;

  logic                   arm_take;
  logic                   match;
  logic [COUNT_WIDTH:0]   cnt_inc;
  logic                   final_match;
  logic                   ext_fire;

  // Disarm outranks arm when both pulse together.
  assign arm_take = i_arm && !i_disarm;

`ifdef TRIGGER_EXT_EN
  assign ext_fire = i_ext_trigger;
`else
  assign ext_fire = 1'b0;
`endif

  trigger_match #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_match (
    .data       (i_data),
    .prev       (prev_reg),
    .prev_valid (prev_valid_reg),
    .mask       (mask_reg),
    .value      (value_reg),
    .edge_mask  (edge_mask_reg),
    .match      (match)
  );

  // Extra bit keeps the compare exact even when the count sits at its maximum.
  assign cnt_inc     = {1'b0, cnt_reg} + {{COUNT_WIDTH{1'b0}}, 1'b1};
  assign final_match = match && (cnt_inc == {1'b0, count_reg});

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (i_disarm) begin
      state_next = ST_IDLE;
    end else if (i_arm) begin
      state_next = ST_ARMED;
      cnt_next   = '0;
    end else begin
      unique case (state_reg)
        ST_ARMED: begin
          if (match) begin
            cnt_next = cnt_inc[COUNT_WIDTH-1:0];
          end
          if (final_match || ext_fire) begin
            state_next = ST_TRIGGERED;
          end
        end
        ST_TRIGGERED: state_next = ST_TRIGGERED;
        default:      state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Config is snapshotted only on an accepted arm; a zero count means "one match".
  always_ff @(posedge clk) begin
    if (reset) begin
      mask_reg      <= '0;
      value_reg     <= '0;
      edge_mask_reg <= '0;
      count_reg     <= {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    end else if (arm_take) begin
      mask_reg      <= i_mask;
      value_reg     <= i_value;
      edge_mask_reg <= i_edge_mask;
      count_reg     <= (i_count == '0) ? {{(COUNT_WIDTH-1){1'b0}}, 1'b1} : i_count;
    end
  end

  // The sample taken on the arm edge may predate the new config, so edges
  // are only trusted one cycle after arming.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_reg       <= '0;
      prev_valid_reg <= 1'b0;
    end else begin
      prev_reg       <= i_data;
      prev_valid_reg <= !arm_take;
    end
  end

  assign o_trigger   = (state_reg == ST_TRIGGERED);
  assign o_armed     = (state_reg == ST_ARMED);
  assign o_match_cnt = cnt_reg;

endmodule

// File: tb/tb_trigger_unit.sv
// Directed table-driven bench for trigger_unit (8-bit data, 8-bit count);
// the external-trigger sequence is exercised when TRIGGER_EXT_EN is defined.
module tb_trigger_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] i_data, i_mask, i_value, i_edge_mask, i_count;
  logic       i_arm, i_disarm;
  logic       i_ext_trigger;
  logic       o_trigger, o_armed;
  logic [7:0] o_match_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  trigger_unit #(
    .DATA_WIDTH  (8),
    .COUNT_WIDTH (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .i_data        (i_data),
    .i_arm         (i_arm),
    .i_disarm      (i_disarm),
    .i_mask        (i_mask),
    .i_value       (i_value),
    .i_edge_mask   (i_edge_mask),
    .i_count       (i_count),
`ifdef TRIGGER_EXT_EN
    .i_ext_trigger (i_ext_trigger),
`endif
    .o_trigger     (o_trigger),
    .o_armed       (o_armed),
    .o_match_cnt   (o_match_cnt)
  );

  typedef struct {
    string      name;
    logic       rst, arm, disarm;
    logic [7:0] data, mask, value, edge_m, count;
    logic       exp_trig, exp_armed;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(string name, logic rst, logic arm, logic disarm,
                              logic [7:0] data, logic [7:0] mask, logic [7:0] value,
                              logic [7:0] edge_m, logic [7:0] count,
                              logic exp_trig, logic exp_armed, logic [7:0] exp_cnt);
    vec_t v;
    v.name = name; v.rst = rst; v.arm = arm; v.disarm = disarm;
    v.data = data; v.mask = mask; v.value = value; v.edge_m = edge_m; v.count = count;
    v.exp_trig = exp_trig; v.exp_armed = exp_armed; v.exp_cnt = exp_cnt;
    vecs.push_back(v);
  endfunction

  task automatic check(string name, logic exp_trig, logic exp_armed, logic [7:0] exp_cnt);
    n_checks += 3;
    if (o_trigger !== exp_trig) begin
      n_fail++;
      $display("FAIL %s trigger: got %b want %b", name, o_trigger, exp_trig);
    end
    if (o_armed !== exp_armed) begin
      n_fail++;
      $display("FAIL %s armed: got %b want %b", name, o_armed, exp_armed);
    end
    if (o_match_cnt !== exp_cnt) begin
      n_fail++;
      $display("FAIL %s match_cnt: got %0d want %0d", name, o_match_cnt, exp_cnt);
    end
    $display("vec %-12s trig=%b armed=%b cnt=%0d", name, o_trigger, o_armed, o_match_cnt);
  endtask

  task automatic apply(vec_t v);
    reset = v.rst; i_arm = v.arm; i_disarm = v.disarm;
    i_data = v.data; i_mask = v.mask; i_value = v.value;
    i_edge_mask = v.edge_m; i_count = v.count;
    @(posedge clk);
    #1;
    check(v.name, v.exp_trig, v.exp_armed, v.exp_cnt);
  endtask

  initial begin
    reset = 1'b1; i_arm = 1'b0; i_disarm = 1'b0; i_ext_trigger = 1'b0;
    i_data = '0; i_mask = '0; i_value = '0; i_edge_mask = '0; i_count = '0;
    #2;

    //   name           rst arm dis data   mask   value  edge   count  trg arm cnt
    add("reset",        1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'd0, 0, 0, 8'd0);
    add("idle",         0, 0, 0, 8'hA5, 8'h00, 8'h00, 8'h00, 8'd0, 0, 0, 8'd0);
    // level match; config inputs scrambled after arm must be ignored
    add("lvl_arm",      0, 1, 0, 8'hA5, 8'hF0, 8'hA0, 8'h00, 8'd1, 0, 1, 8'd0);
    add("lvl_w1",       0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'd9, 0, 1, 8'd0);
    add("lvl_w2",       0, 0, 0, 8'h0A, 8'hFF, 8'h0A, 8'h00, 8'd1, 0, 1, 8'd0);
    add("lvl_hit",      0, 0, 0, 8'hA5, 8'h00, 8'h00, 8'h00, 8'd9, 1, 0, 8'd1);
    for (int i = 0; i < 10; i++)
      add("lvl_sticky", 0, 0, 0, (i[0] ? 8'hA5 : 8'h00), 8'h00, 8'h00, 8'h00, 8'd0, 1, 0, 8'd1);
    // count of 3 from TRIGGERED via re-arm
    add("cnt_arm",      0, 1, 0, 8'h00, 8'hFF, 8'h55, 8'h00, 8'd3, 0, 1, 8'd0);
    add("cnt_m1",       0, 0, 0, 8'h55, 8'h00, 8'h00, 8'h00, 8'd0, 0, 1, 8'd1);
    add("cnt_gap1",     0, 0, 0, 8'h54, 8'h00, 8'h00, 8'h00, 8'd0, 0, 1, 8'd1);
    add("cnt_m2",       0, 0, 0, 8'h55, 8'h00, 8'h00, 8'h00, 8'd0, 0, 1, 8'd2);
    add("cnt_gap2",     0, 0, 0, 8'hD5, 8'h00, 8'h00, 8'h00, 8'd0, 0, 1, 8'd2);
    add("cnt_gap3",     0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'd0, 0, 1, 8'd2);
    add("cnt_m3",       0, 0, 0, 8'h55, 8'h00, 8'h00, 8'h00, 8'd0, 1, 0, 8'd3);
    add("cnt_frozen",   0, 0, 0, 8'h55, 8'h00, 8'h00, 8'h00, 8'd0, 1, 0, 8'd3);
    // rising edge on bit 0; level 1 held across arm must not count
    add("edg_pre",      0, 0, 0, 8'h01, 8'h00, 8'h00, 8'h00, 8'd0, 1, 0, 8'd3);
    add("edg_arm",      0, 1, 0, 8'h01, 8'h00, 8'h01, 8'h01, 8'd1, 0, 1, 8'd0);
    add("edg_hold1",    0, 0, 0, 8'h01, 8'h00, 8'h00, 8'h00, 8'd0, 0, 1, 8'd0);
    add("edg_hold2",    0, 0, 0, 8'h01, 8'h00, 8'h00, 8'h00, 8'd0, 0, 1, 8'd0);
    add("edg_fall",     0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'd0, 0, 1, 8'd0);
    add("edg_rise",     0, 0, 0, 8'h01, 8'h00, 8'h00, 8'h00, 8'd0, 1, 0, 8'd1);
    // arm+disarm together: disarm wins, count held
    add("pri_both",     0, 1, 1, 8'h3C, 8'hFF, 8'h3C, 8'h00, 8'd0, 0, 0, 8'd1);
    add("pri_arm0",     0, 1, 0, 8'h00, 8'hFF, 8'h3C, 8'h00, 8'd0, 0, 1, 8'd0);
    add("pri_hit",      0, 0, 0, 8'h3C, 8'h00, 8'h00, 8'h00, 8'd0, 1, 0, 8'd1);
    // disarm while ARMED beats a same-cycle match
    add("dis_arm",      0, 1, 0, 8'h00, 8'hFF, 8'h77, 8'h00, 8'd5, 0, 1, 8'd0);
    add("dis_m1",       0, 0, 0, 8'h77, 8'h00, 8'h00, 8'h00, 8'd0, 0, 1, 8'd1);
    add("dis_match",    0, 0, 1, 8'h77, 8'h00, 8'h00, 8'h00, 8'd0, 0, 0, 8'd1);
    add("dis_idle",     0, 0, 0, 8'h77, 8'h00, 8'h00, 8'h00, 8'd0, 0, 0, 8'd1);
    // don't-care mask matches every armed cycle
    add("any_arm",      0, 1, 0, 8'h12, 8'h00, 8'hFF, 8'h00, 8'd2, 0, 1, 8'd0);
    add("any_m1",       0, 0, 0, 8'h34, 8'h00, 8'h00, 8'h00, 8'd0, 0, 1, 8'd1);
    add("any_m2",       0, 0, 0, 8'h56, 8'h00, 8'h00, 8'h00, 8'd0, 1, 0, 8'd2);
    // reset mid-operation
    add("rst_arm",      0, 1, 0, 8'h00, 8'hFF, 8'h11, 8'h00, 8'd4, 0, 1, 8'd0);
    add("rst_m1",       0, 0, 0, 8'h11, 8'h00, 8'h00, 8'h00, 8'd0, 0, 1, 8'd1);
    add("rst_m2",       0, 0, 0, 8'h11, 8'h00, 8'h00, 8'h00, 8'd0, 0, 1, 8'd2);
    add("rst_hit",      1, 1, 0, 8'h11, 8'hFF, 8'h11, 8'h00, 8'd1, 0, 0, 8'd0);
    add("rst_noarm1",   0, 0, 0, 8'h11, 8'h00, 8'h00, 8'h00, 8'd0, 0, 0, 8'd0);
    add("rst_noarm2",   0, 0, 0, 8'h11, 8'h00, 8'h00, 8'h00, 8'd0, 0, 0, 8'd0);

    foreach (vecs[i]) apply(vecs[i]);

    // External trigger: count 5, data never matches
    reset = 1'b0; i_disarm = 1'b0;
    i_arm = 1'b1; i_mask = 8'hFF; i_value = 8'hAA; i_edge_mask = 8'h00; i_count = 8'd5;
    i_data = 8'h00;
    @(posedge clk); #1;
    check("ext_arm", 1'b0, 1'b1, 8'd0);
    i_arm = 1'b0;
    @(posedge clk); #1;
    check("ext_wait", 1'b0, 1'b1, 8'd0);
    i_ext_trigger = 1'b1;
    @(posedge clk); #1;
`ifdef TRIGGER_EXT_EN
    check("ext_fire", 1'b1, 1'b0, 8'd0);
`else
    check("ext_absent", 1'b0, 1'b1, 8'd0);
`endif
    i_ext_trigger = 1'b0;
    @(posedge clk); #1;
`ifdef TRIGGER_EXT_EN
    check("ext_sticky", 1'b1, 1'b0, 8'd0);
`else
    check("ext_still", 1'b0, 1'b1, 8'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
